// File: rtl/float_pkg.sv
// Shared BF16 definitions for the accumulator: field widths, constants,
// FSM state encoding and a small mantissa helper.
package float_pkg;

    localparam int BF16_W      = 16;
    localparam int BF16_EXP_W  = 8;
    localparam int BF16_FRAC_W = 7;
    localparam int BF16_MANT_W = BF16_FRAC_W + 1;
    localparam int BF16_BIAS   = 127;

    localparam logic [BF16_W-1:0]   BF16_MAX_FINITE = 16'h7F7F;
    localparam logic [BF16_EXP_W:0] BF16_EXP_LIMIT  = 9'd254;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_ADD   = 2'd2,
        ST_NORM  = 2'd3
    } acc_state_e;

    // Hidden-one mantissa; exponent 0 (zero or denormal) reads as zero.
    function automatic logic [BF16_MANT_W-1:0] bf16_mant(input logic [BF16_W-1:0] v);
        logic [BF16_MANT_W-1:0] m;
        if (v[BF16_W-2:BF16_FRAC_W] == 8'd0) begin
            m = 8'd0;
        end else begin
            m = {1'b1, v[BF16_FRAC_W-1:0]};
        end
        return m;
    endfunction

endpackage

// File: rtl/bf16_align.sv
// Combinational operand alignment: picks the larger exponent and shifts the
// other operand's mantissa right by the difference (truncating, no guard
// bits). Shifts of 8 or more leave nothing of an 8-bit mantissa, so they
// flush to zero.
module bf16_align
    import float_pkg::*;
(
    input  logic [BF16_EXP_W-1:0]  exp_a,
    input  logic [BF16_EXP_W-1:0]  exp_b,
    input  logic [BF16_MANT_W-1:0] mant_a_in,
    input  logic [BF16_MANT_W-1:0] mant_b_in,
    output logic [BF16_EXP_W-1:0]  exp_max,
    output logic [BF16_MANT_W-1:0] mant_a_out,
    output logic [BF16_MANT_W-1:0] mant_b_out
);

    logic [BF16_EXP_W-1:0] diff_s;

    function automatic logic [BF16_MANT_W-1:0] shift_flush(
        input logic [BF16_MANT_W-1:0] m,
        input logic [BF16_EXP_W-1:0]  d
    );
        logic [BF16_MANT_W-1:0] r;
        if (d >= 8'd8) begin
            r = 8'd0;
        end else begin
            r = m >> d[2:0];
        end
        return r;
    endfunction

    // Exponent compare and shift of the smaller operand.
    always_comb begin
        exp_max    = 8'd0;
        diff_s     = 8'd0;
        mant_a_out = 8'd0;
        mant_b_out = 8'd0;
        if (exp_a >= exp_b) begin
            exp_max    = exp_a;
            diff_s     = exp_a - exp_b;
            mant_a_out = mant_a_in;
            mant_b_out = shift_flush(mant_b_in, diff_s);
        end else begin
            exp_max    = exp_b;
            diff_s     = exp_b - exp_a;
            mant_a_out = shift_flush(mant_a_in, diff_s);
            mant_b_out = mant_b_in;
        end
    end

endmodule

// File: rtl/float_accumulator_bf16.sv
// BF16 accumulator: sum <= sum + in_data, one addend at a time, through an
// IDLE -> ALIGN -> ADD -> NORM sequence. Inf/NaN exponents are handled as
// ordinary finite values; rounding is plain truncation.
module float_accumulator_bf16
    import float_pkg::*;
#(
    parameter bit SAT_ON_OVF = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BF16_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    output logic [BF16_W-1:0] sum,
    output logic              sum_valid
);

    acc_state_e state_r;
    acc_state_e state_next_s;

    logic [BF16_W-1:0]      addend_r;
    logic [BF16_W-1:0]      sum_r;
    logic                   sum_valid_r;
    logic [BF16_EXP_W:0]    exp_r;
    logic [BF16_MANT_W-1:0] mant_a_r;
    logic [BF16_MANT_W-1:0] mant_b_r;
    logic                   sign_a_r;
    logic                   sign_b_r;
    logic [BF16_MANT_W:0]   mant_r;
    logic                   sign_r;

    logic [BF16_EXP_W-1:0]  align_exp_s;
    logic [BF16_MANT_W-1:0] align_mant_a_s;
    logic [BF16_MANT_W-1:0] align_mant_b_s;

    logic [BF16_MANT_W:0]   add_mag_s;
    logic                   add_sign_s;

    logic                   norm_done_s;
    logic [BF16_W-1:0]      norm_result_s;
    logic [BF16_MANT_W:0]   norm_mant_next_s;
    logic [BF16_EXP_W:0]    norm_exp_next_s;

    // Exponents above 254 either saturate to max finite or keep the low
    // eight exponent bits, depending on SAT_ON_OVF.
    function automatic logic [BF16_W-1:0] bf16_pack(
        input logic                   s,
        input logic [BF16_EXP_W:0]    e,
        input logic [BF16_FRAC_W-1:0] f
    );
        logic [BF16_W-1:0] r;
        if (e > BF16_EXP_LIMIT) begin
            if (SAT_ON_OVF) begin
                r = {s, BF16_MAX_FINITE[BF16_W-2:0]};
            end else begin
                r = {s, e[BF16_EXP_W-1:0], f};
            end
        end else begin
            r = {s, e[BF16_EXP_W-1:0], f};
        end
        return r;
    endfunction

    bf16_align u_align (
        .exp_a      (sum_r[BF16_W-2:BF16_FRAC_W]),
        .exp_b      (addend_r[BF16_W-2:BF16_FRAC_W]),
        .mant_a_in  (bf16_mant(sum_r)),
        .mant_b_in  (bf16_mant(addend_r)),
        .exp_max    (align_exp_s),
        .mant_a_out (align_mant_a_s),
        .mant_b_out (align_mant_b_s)
    );

    // State register; clear aborts any operation and wins over in_valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else if (clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode for the add sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next_s = ST_ALIGN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ALIGN: state_next_s = ST_ADD;
            ST_ADD:   state_next_s = ST_NORM;
            ST_NORM: begin
                if (norm_done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_NORM;
                end
            end
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Signed-magnitude add: larger magnitude keeps its sign on subtraction.
    always_comb begin
        add_mag_s  = 9'd0;
        add_sign_s = 1'b0;
        if (sign_a_r == sign_b_r) begin
            add_mag_s  = {1'b0, mant_a_r} + {1'b0, mant_b_r};
            add_sign_s = sign_a_r;
        end else if (mant_a_r >= mant_b_r) begin
            add_mag_s  = {1'b0, mant_a_r - mant_b_r};
            add_sign_s = sign_a_r;
        end else begin
            add_mag_s  = {1'b0, mant_b_r - mant_a_r};
            add_sign_s = sign_b_r;
        end
    end

    // One normalisation step per cycle: carry-out, done, zero, or shift left.
    always_comb begin
        norm_done_s      = 1'b0;
        norm_result_s    = 16'h0000;
        norm_mant_next_s = mant_r;
        norm_exp_next_s  = exp_r;
        if (mant_r[BF16_MANT_W]) begin
            norm_done_s   = 1'b1;
            norm_result_s = bf16_pack(sign_r, exp_r + 9'd1, mant_r[BF16_FRAC_W:1]);
        end else if (mant_r[BF16_FRAC_W]) begin
            norm_done_s   = 1'b1;
            norm_result_s = bf16_pack(sign_r, exp_r, mant_r[BF16_FRAC_W-1:0]);
        end else if (mant_r == 9'd0) begin
            norm_done_s   = 1'b1;
            norm_result_s = 16'h0000;
        end else begin
            norm_mant_next_s = {mant_r[BF16_MANT_W-1:0], 1'b0};
            norm_exp_next_s  = exp_r - 9'd1;
            if (norm_exp_next_s == 9'd0) begin
                norm_done_s   = 1'b1;
                norm_result_s = 16'h0000;
            end else begin
                norm_done_s   = 1'b0;
                norm_result_s = 16'h0000;
            end
        end
    end

    // Datapath registers, accumulator and the one-cycle sum_valid pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            addend_r    <= 16'h0000;
            sum_r       <= 16'h0000;
            sum_valid_r <= 1'b0;
            exp_r       <= 9'd0;
            mant_a_r    <= 8'd0;
            mant_b_r    <= 8'd0;
            sign_a_r    <= 1'b0;
            sign_b_r    <= 1'b0;
            mant_r      <= 9'd0;
            sign_r      <= 1'b0;
        end else begin
            sum_valid_r <= 1'b0;
            if (clear) begin
                sum_r <= 16'h0000;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (in_valid) begin
                            addend_r <= in_data;
                        end
                    end
                    ST_ALIGN: begin
                        exp_r    <= {1'b0, align_exp_s};
                        mant_a_r <= align_mant_a_s;
                        mant_b_r <= align_mant_b_s;
                        sign_a_r <= sum_r[BF16_W-1];
                        sign_b_r <= addend_r[BF16_W-1];
                    end
                    ST_ADD: begin
                        mant_r <= add_mag_s;
                        sign_r <= add_sign_s;
                    end
                    ST_NORM: begin
                        mant_r <= norm_mant_next_s;
                        exp_r  <= norm_exp_next_s;
                        if (norm_done_s) begin
                            sum_r       <= norm_result_s;
                            sum_valid_r <= 1'b1;
                        end
                    end
                    default: begin
                        sum_r <= sum_r;
                    end
                endcase
            end
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign sum       = sum_r;
    assign sum_valid = sum_valid_r;

endmodule

// File: tb/tb_float_accumulator_bf16.sv
// Scoreboard bench for float_accumulator_bf16: directed cases plus random
// addends checked against an integer-arithmetic reference model.
module tb_float_accumulator_bf16;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        clear;
    logic [15:0] sum;
    logic        sum_valid;

    float_accumulator_bf16 #(.SAT_ON_OVF(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clear     (clear),
        .sum       (sum),
        .sum_valid (sum_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] val;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          done_cnt = 0;
    logic [15:0] model_acc = 16'h0000;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every sum_valid pulse against the scoreboard head.
    always @(negedge clock) begin
        if (sum_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse sum=%h expected no sum_valid", sum);
            end else begin
                mon_e = sb_q.pop_front();
                total++;
                if (sum !== mon_e.val) begin
                    bad++;
                    $display("FAIL sum got=%h want=%h", sum, mon_e.val);
                end
                total++;
                if ((cyc - accept_cyc) != mon_e.lat) begin
                    bad++;
                    $display("FAIL latency got=%0d want=%0d", cyc - accept_cyc, mon_e.lat);
                end
            end
            done_cnt++;
        end
        if (in_valid && in_ready && !clear && !reset) accept_cyc = cyc + 1;
    end

    // Reference: exact integer alignment/add, then normalise with loops.
    task automatic model_add(input logic [15:0] a, input logic [15:0] b,
                             output logic [15:0] r, output int ncyc);
        int ea, eb, ma, mb, e, d, tot, mag;
        bit neg, zero;
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        ma = (ea == 0) ? 0 : 128 + int'(a[6:0]);
        mb = (eb == 0) ? 0 : 128 + int'(b[6:0]);
        if (ea >= eb) begin
            e = ea; d = ea - eb;
            mb = (d >= 8) ? 0 : mb / (1 << d);
        end else begin
            e = eb; d = eb - ea;
            ma = (d >= 8) ? 0 : ma / (1 << d);
        end
        tot  = (a[15] ? -ma : ma) + (b[15] ? -mb : mb);
        neg  = (tot < 0);
        mag  = neg ? -tot : tot;
        zero = 1'b0;
        if (mag == 0) begin
            zero = 1'b1; ncyc = 1;
        end else if (mag >= 256) begin
            mag = mag / 2; e = e + 1; ncyc = 1;
        end else begin
            ncyc = 0;
            while (mag < 128 && !zero) begin
                mag = mag * 2; e = e - 1; ncyc++;
                if (e == 0) zero = 1'b1;
            end
            if (!zero) ncyc++;
        end
        if (zero) r = 16'h0000;
        else if (e > 254) r = {neg, 15'h7F7F};
        else r = {neg, 8'(e), 7'(mag % 128)};
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic wait_done(input int start);
        for (int i = 0; i < 30 && done_cnt == start; i++) tick();
        total++;
        if (done_cnt == start) begin
            bad++;
            $display("FAIL timeout got=no sum_valid want=sum_valid within 30 cycles");
        end
    endtask

    task automatic do_add(input logic [15:0] v);
        logic [15:0] r;
        int n;
        int start;
        model_add(model_acc, v, r, n);
        sb_q.push_back('{val: r, lat: n + 2});
        model_acc = r;
        start = done_cnt;
        in_data  = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 65535);
        wait_done(start);
    endtask

    task automatic clear_idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_acc = 16'h0000;
        check("clear_idle_sum", sum, 16'h0000);
    endtask

    task automatic expect_quiet(input string name, input int start);
        repeat (8) tick();
        check(name, 16'(done_cnt - start), 16'h0000);
    endtask

    function automatic logic [15:0] rand_bf16();
        logic [7:0] e;
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) e = 8'd0;
        else if (sel == 1) e = 8'($urandom_range(250, 254));
        else e = 8'($urandom_range(118, 136));
        return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
    endfunction

    initial begin
        int start;
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_sum", sum, 16'h0000);
        check("reset_ready", {15'd0, in_ready}, 16'h0001);
        check("reset_valid", {15'd0, sum_valid}, 16'h0000);

        do_add(16'h3F80);
        check("one_plus_zero", sum, 16'h3F80);
        do_add(16'h3F80);
        check("one_plus_one", sum, 16'h4000);

        clear_idle();
        do_add(16'h4040);
        do_add(16'hBF80);
        check("three_minus_one", sum, 16'h4000);
        do_add(16'hC000);
        check("cancel_to_zero", sum, 16'h0000);

        clear_idle();
        do_add(16'h3F80);
        do_add(16'h3B80);
        check("shift8_flushed", sum, 16'h3F80);
        do_add(16'h3C00);
        check("shift7_kept", sum, 16'h3F81);

        clear_idle();
        do_add(16'h7F7F);
        do_add(16'h7F7F);
        check("overflow_sat", sum, 16'h7F7F);

        clear_idle();
        do_add(16'h8000);
        check("negzero_sum", sum, 16'h0000);
        do_add(16'hC0A0);
        check("x_plus_zero", sum, 16'hC0A0);
        do_add(16'h0001);
        check("x_plus_denorm", sum, 16'hC0A0);

        clear_idle();
        do_add(16'h00C0);
        do_add(16'h8080);
        check("exp_underflow", sum, 16'h0000);

        // clear together with in_valid in IDLE
        do_add(16'h3F80);
        start = done_cnt;
        clear = 1'b1; in_valid = 1'b1; in_data = 16'h4000;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        model_acc = 16'h0000;
        check("clr_idle_sum", sum, 16'h0000);
        check("clr_idle_ready", {15'd0, in_ready}, 16'h0001);
        expect_quiet("clr_idle_no_pulse", start);
        check("clr_idle_sum_after", sum, 16'h0000);

        // clear while in NORM
        do_add(16'h3F80);
        start = done_cnt;
        in_data = 16'h4000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_acc = 16'h0000;
        check("clr_norm_sum", sum, 16'h0000);
        check("clr_norm_ready", {15'd0, in_ready}, 16'h0001);
        check("clr_norm_valid", {15'd0, sum_valid}, 16'h0000);
        expect_quiet("clr_norm_no_pulse", start);

        // reset mid-operation
        do_add(16'h4000);
        start = done_cnt;
        in_data = 16'h4000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_acc = 16'h0000;
        check("rst_mid_sum", sum, 16'h0000);
        check("rst_mid_ready", {15'd0, in_ready}, 16'h0001);
        expect_quiet("rst_mid_no_pulse", start);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 11) == 0) clear_idle();
            else do_add(rand_bf16());
        end

        repeat (4) tick();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
